// File: rtl/piso_pkg.sv
// Shared types and defaults for the piso_tx serial transmitter.
// Optional odd-parity bit is enabled by defining PISO_TX_PARITY_EN.
package piso_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int unsigned WIDTH_DEF  = 4;
    localparam int unsigned PERIOD_DEF = 134217728;

endpackage

// File: rtl/piso_tx_if.sv
// Load handshake and serial output bundle between a word source and piso_tx.
interface piso_tx_if
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) ();

    logic [WIDTH-1:0] DIN;
    logic             LD;
    logic             RDY;
    logic             SO;
    logic             SOE;
    logic             DONE;

    modport master (
        output DIN,
        output LD,
        input  RDY,
        input  SO,
        input  SOE,
        input  DONE
    );

    modport slave (
        input  DIN,
        input  LD,
        output RDY,
        output SO,
        output SOE,
        output DONE
    );

endinterface

// File: rtl/piso_tx_bit_timer.sv
// Restartable divider: one-cycle tick every PERIOD enabled cycles, held at 0 by clear.
module bit_timer
    import piso_pkg::*;
#(
    parameter int unsigned PERIOD = PERIOD_DEF
) (
    input  logic CLK,
    input  logic R_N,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick = enable && (cnt == CNT_W'(PERIOD - 1));

    always_ff @(posedge CLK) begin
        if (!R_N) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter, MSB first, each bit held PERIOD cycles.
// Define PISO_TX_PARITY_EN to append an odd parity bit after the data LSB.
module piso_tx
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned PERIOD = PERIOD_DEF
) (
    input  logic     CLK,
    input  logic     R_N,
    piso_tx_if.slave bus
);

`ifdef PISO_TX_PARITY_EN
    localparam int unsigned FRAME_W = WIDTH + 1;
`else
    localparam int unsigned FRAME_W = WIDTH;
`endif
    localparam int unsigned BCNT_W = $clog2(FRAME_W);

    state_t               state;
    logic [FRAME_W-1:0]   shreg;
    logic [FRAME_W-1:0]   load_c;
    logic [BCNT_W-1:0]    bcnt;
    logic                 so_q;
    logic                 soe_q;
    logic                 rdy_q;
    logic                 done_q;
    logic                 tick;
    logic                 timer_clear_c;
    logic                 timer_en_c;

    // Frame image captured at accept; parity sits below the data LSB.
    always_comb begin
        load_c = '0;
`ifdef PISO_TX_PARITY_EN
        load_c = {bus.DIN, ~^bus.DIN};
`else
        load_c = bus.DIN;
`endif
    end

    assign timer_clear_c = (state == ST_IDLE);
    assign timer_en_c    = (state == ST_SHIFT);

    bit_timer #(
        .PERIOD (PERIOD)
    ) u_bit_timer (
        .CLK    (CLK),
        .R_N    (R_N),
        .clear  (timer_clear_c),
        .enable (timer_en_c),
        .tick   (tick)
    );

    // Outputs are updated together with the state so they always match it.
    always_ff @(posedge CLK) begin
        if (!R_N) begin
            state  <= ST_IDLE;
            shreg  <= '0;
            bcnt   <= '0;
            so_q   <= 1'b0;
            soe_q  <= 1'b0;
            rdy_q  <= 1'b1;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == ST_IDLE) begin
                bcnt <= '0;
                if (bus.LD) begin
                    state <= ST_SHIFT;
                    shreg <= load_c;
                    so_q  <= load_c[FRAME_W-1];
                    soe_q <= 1'b1;
                    rdy_q <= 1'b0;
                end
            end else if (tick) begin
                if (bcnt == BCNT_W'(FRAME_W - 1)) begin
                    state  <= ST_IDLE;
                    bcnt   <= '0;
                    so_q   <= 1'b0;
                    soe_q  <= 1'b0;
                    rdy_q  <= 1'b1;
                    done_q <= 1'b1;
                end else begin
                    shreg <= {shreg[FRAME_W-2:0], 1'b0};
                    so_q  <= shreg[FRAME_W-2];
                    bcnt  <= bcnt + BCNT_W'(1);
                end
            end
        end
    end

    assign bus.SO   = so_q;
    assign bus.SOE  = soe_q;
    assign bus.RDY  = rdy_q;
    assign bus.DONE = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx (WIDTH=4, PERIOD=4): vector table, corner sequences, random vs frame model.
// Honours PISO_TX_PARITY_EN when the RTL is built with it.
module tb_piso_tx;

    localparam int W = 4;
    localparam int P = 4;
`ifdef PISO_TX_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif
    localparam int FLEN = FRAME * P;

    logic clk;
    logic r_n;

    piso_tx_if #(.WIDTH(W)) bus ();

    piso_tx #(.WIDTH(W), .PERIOD(P)) dut (
        .CLK (clk),
        .R_N (r_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Frame model: a frame accepted at edge t0 occupies cycles t0+1 .. t0+FLEN.
    bit               m_active = 1'b0;
    int               m_t0     = 0;
    logic [FRAME-1:0] m_bits   = '0;

    function automatic logic [FRAME-1:0] frame_of(logic [W-1:0] d);
`ifdef PISO_TX_PARITY_EN
        return {d, ~^d};
`else
        return d;
`endif
    endfunction

    function automatic bit in_frame(int c);
        return m_active && (c >= m_t0 + 1) && (c <= m_t0 + FLEN);
    endfunction

    function automatic logic exp_so(int c);
        int k;
        if (!in_frame(c)) return 1'b0;
        k = (c - m_t0 - 1) / P;
        return m_bits[FRAME-1-k];
    endfunction

    function automatic logic exp_done(int c);
        return m_active && (c == m_t0 + FLEN + 1);
    endfunction

    task automatic chk(string nm, logic act, logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_model(string tag);
        chk({tag, "_so"},   bus.SO,   exp_so(cyc));
        chk({tag, "_soe"},  bus.SOE,  logic'(in_frame(cyc)));
        chk({tag, "_rdy"},  bus.RDY,  logic'(!in_frame(cyc)));
        chk({tag, "_done"}, bus.DONE, exp_done(cyc));
    endtask

    // Apply inputs for one edge, advance the model, sample on the falling edge.
    task automatic step(logic rn, logic ld, logic [W-1:0] din);
        r_n     = rn;
        bus.LD  = ld;
        bus.DIN = din;
        @(posedge clk);
        if (!rn) begin
            m_active = 1'b0;
        end else if (!in_frame(cyc) && ld) begin
            m_active = 1'b1;
            m_t0     = cyc;
            m_bits   = frame_of(din);
        end
        cyc++;
        @(negedge clk);
    endtask

    typedef struct {
        logic         rn;
        logic         ld;
        logic [W-1:0] din;
        int           n;
        logic         so;
        logic         soe;
        logic         rdy;
        logic         done;
    } vec_t;

    vec_t vt[$];

    initial begin
        // Reset with a pending load, then one 1011 frame with a busy load at edge t+6.
        vt.push_back('{1'b0, 1'b1, 4'hF, 2, 1'b0, 1'b0, 1'b1, 1'b0});
        vt.push_back('{1'b1, 1'b1, 4'hB, 1, 1'b1, 1'b1, 1'b0, 1'b0});
        vt.push_back('{1'b1, 1'b0, 4'h0, 3, 1'b1, 1'b1, 1'b0, 1'b0});
        vt.push_back('{1'b1, 1'b0, 4'h0, 2, 1'b0, 1'b1, 1'b0, 1'b0});
        vt.push_back('{1'b1, 1'b1, 4'h5, 1, 1'b0, 1'b1, 1'b0, 1'b0});
        vt.push_back('{1'b1, 1'b0, 4'h0, 1, 1'b0, 1'b1, 1'b0, 1'b0});
        vt.push_back('{1'b1, 1'b0, 4'h0, 8, 1'b1, 1'b1, 1'b0, 1'b0});
`ifdef PISO_TX_PARITY_EN
        vt.push_back('{1'b1, 1'b0, 4'h0, 4, 1'b0, 1'b1, 1'b0, 1'b0});
`endif
        vt.push_back('{1'b1, 1'b0, 4'h0, 1, 1'b0, 1'b0, 1'b1, 1'b1});
        vt.push_back('{1'b1, 1'b0, 4'h0, 2, 1'b0, 1'b0, 1'b1, 1'b0});

        foreach (vt[i]) begin
            for (int j = 0; j < vt[i].n; j++) begin
                step(vt[i].rn, vt[i].ld, vt[i].din);
                chk($sformatf("tbl%0d_so", i),   bus.SO,   vt[i].so);
                chk($sformatf("tbl%0d_soe", i),  bus.SOE,  vt[i].soe);
                chk($sformatf("tbl%0d_rdy", i),  bus.RDY,  vt[i].rdy);
                chk($sformatf("tbl%0d_done", i), bus.DONE, vt[i].done);
            end
        end

        // Back-to-back: LD held high, second accept lands in the DONE cycle.
        for (int k = 1; k <= 2 * FLEN + 2; k++) begin
            step(1'b1, 1'b1, 4'h3);
            chk_model("b2b");
            if (k == FLEN + 1) begin
                chk("b2b_gap_so",   bus.SO,   1'b0);
                chk("b2b_gap_soe",  bus.SOE,  1'b0);
                chk("b2b_gap_done", bus.DONE, 1'b1);
            end
            if (k == FLEN + 2) begin
                chk("b2b_second_soe", bus.SOE, 1'b1);
                chk("b2b_second_so",  bus.SO,  1'b0);
            end
        end
        for (int k = 0; k < FLEN + 2; k++) step(1'b1, 1'b0, 4'h0);

        // Reset mid-frame abandons it; a fresh all-ones frame follows.
        step(1'b1, 1'b1, 4'hF);
        for (int k = 2; k <= 6; k++) step(1'b1, 1'b0, 4'h0);
        step(1'b0, 1'b0, 4'h0);
        chk("rstmid_so",   bus.SO,   1'b0);
        chk("rstmid_soe",  bus.SOE,  1'b0);
        chk("rstmid_rdy",  bus.RDY,  1'b1);
        chk("rstmid_done", bus.DONE, 1'b0);
        step(1'b1, 1'b0, 4'h0);
        chk("rstmid_nodone", bus.DONE, 1'b0);
        step(1'b1, 1'b1, 4'hF);
        chk("reload_so", bus.SO, 1'b1);
        for (int k = 1; k < FLEN; k++) begin
            step(1'b1, 1'b0, 4'h0);
            chk("reload_so", bus.SO, 1'b1);
            chk_model("reload");
        end
        step(1'b1, 1'b0, 4'h0);
        chk("reload_done", bus.DONE, 1'b1);

`ifdef PISO_TX_PARITY_EN
        // Parity of 1001 is 1: fifth bit high.
        step(1'b1, 1'b1, 4'h9);
        for (int k = 1; k < FLEN; k++) step(1'b1, 1'b0, 4'h0);
        chk("par_1001_bit4", bus.SO, 1'b1);
        step(1'b1, 1'b0, 4'h0);
        chk("par_1001_done", bus.DONE, 1'b1);
`endif

        // Random traffic against the frame model.
        for (int k = 0; k < 600; k++) begin
            step(logic'(($urandom % 64) != 0), logic'(($urandom % 4) == 0), W'($urandom));
            chk_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
